// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants, exception codes and the stage bundle for the pipeline stage registers.
package pipe_pkg;

  localparam int unsigned EXC_W = 5;

  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_W-1:0] EXC_BP   = 5'd9;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic             bd;
    logic [EXC_W-1:0] exc;
    logic             valid;
  } stage_t;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_REDIRECT
  } stage_act_e;

  // Fixed per-edge priority: req > flush > stall > load.
  function automatic stage_act_e select_act(input logic req, input logic flush,
                                            input logic stall);
    if (req)   return ACT_REDIRECT;
    if (flush) return ACT_BUBBLE;
    if (stall) return ACT_HOLD;
    return ACT_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Control, upstream and registered-stage signals of one pipeline stage register.
interface pipe_stage_reg_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned EXC_W   = pipe_pkg::EXC_W,
  parameter int unsigned CNT_W   = 8
) ();
  logic               req;
  logic               flush;
  logic               stall;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               in_bd;
  logic [EXC_W-1:0]   in_exc;
  logic               in_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [PC_W-1:0]    out_pc8;
  logic               out_bd;
  logic [EXC_W-1:0]   out_exc;
  logic               out_valid;
  logic [CNT_W-1:0]   stall_cnt;
  logic               stall_long;

  modport master (
    output req, flush, stall, in_instr, in_pc, in_bd, in_exc, in_valid,
    input  out_instr, out_pc, out_pc8, out_bd, out_exc, out_valid, stall_cnt, stall_long
  );

  modport slave (
    input  req, flush, stall, in_instr, in_pc, in_bd, in_exc, in_valid,
    output out_instr, out_pc, out_pc8, out_bd, out_exc, out_valid, stall_cnt, stall_long
  );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; next value exposed for registered threshold flags.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] next_o
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;
endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with redirect, bubble, hold and a saturating stall-length monitor.
module pipe_stage_reg #(
  parameter int unsigned             INSTR_W     = 32,
  parameter int unsigned             PC_W        = 32,
  parameter int unsigned             EXC_W       = pipe_pkg::EXC_W,
  parameter logic [PC_W-1:0]         RESET_PC    = pipe_pkg::RESET_PC,
  parameter logic [PC_W-1:0]         HANDLER_PC  = pipe_pkg::HANDLER_PC,
  parameter logic [INSTR_W-1:0]      NOP         = pipe_pkg::NOP,
  parameter int unsigned             CNT_W       = 8,
  parameter logic [CNT_W-1:0]        STALL_LIMIT = 8'd64
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);
  localparam logic [PC_W-1:0] PC_INC = PC_W'(8);

  pipe_pkg::stage_act_e act;

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    pc8_q, pc8_d;
  logic               bd_q, bd_d;
  logic [EXC_W-1:0]   exc_q, exc_d;
  logic               valid_q, valid_d;
  logic               long_q;

  logic               cnt_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_next;

  assign act = pipe_pkg::select_act(bus.req, bus.flush, bus.stall);

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc8_d   = pc8_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    valid_d = valid_q;
    unique case (act)
      pipe_pkg::ACT_REDIRECT: begin
        instr_d = NOP;
        pc_d    = HANDLER_PC;
        pc8_d   = HANDLER_PC + PC_INC;
        bd_d    = 1'b0;
        exc_d   = '0;
        valid_d = 1'b0;
      end
      // Bubble keeps the displaced PC/BD so a later exception can still report a precise EPC.
      pipe_pkg::ACT_BUBBLE: begin
        instr_d = NOP;
        pc_d    = bus.in_pc;
        pc8_d   = bus.in_pc + PC_INC;
        bd_d    = bus.in_bd;
        exc_d   = '0;
        valid_d = 1'b0;
      end
      pipe_pkg::ACT_HOLD: begin
      end
      pipe_pkg::ACT_LOAD: begin
        instr_d = bus.in_instr;
        pc_d    = bus.in_pc;
        pc8_d   = bus.in_pc + PC_INC;
        bd_d    = bus.in_bd;
        exc_d   = bus.in_exc;
        valid_d = bus.in_valid;
      end
    endcase
  end

  assign cnt_inc = (act == pipe_pkg::ACT_HOLD);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (cnt_inc),
    .clr_i   (!cnt_inc),
    .count_o (cnt_q),
    .next_o  (cnt_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP;
      pc_q    <= RESET_PC;
      pc8_q   <= RESET_PC + PC_INC;
      bd_q    <= 1'b0;
      exc_q   <= '0;
      valid_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc8_q   <= pc8_d;
      bd_q    <= bd_d;
      exc_q   <= exc_d;
      valid_q <= valid_d;
      long_q  <= (cnt_next >= STALL_LIMIT);
    end
  end

  assign bus.out_instr  = instr_q;
  assign bus.out_pc     = pc_q;
  assign bus.out_pc8    = pc8_q;
  assign bus.out_bd     = bd_q;
  assign bus.out_exc    = exc_q;
  assign bus.out_valid  = valid_q;
  assign bus.stall_cnt  = cnt_q;
  assign bus.stall_long = long_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, per-DUT monitors pop and compare.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  typedef struct {
    stage_t      s;
    logic [31:0] pc8;
    logic [7:0]  cnt;
    logic        lng;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  pipe_stage_reg_if #(.INSTR_W(32), .PC_W(32), .EXC_W(5), .CNT_W(8)) ifa ();
  pipe_stage_reg_if #(.INSTR_W(32), .PC_W(32), .EXC_W(5), .CNT_W(3)) ifb ();

  pipe_stage_reg #(.CNT_W(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  pipe_stage_reg #(.CNT_W(3), .STALL_LIMIT(3'd5)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_a(input logic r, input logic f, input logic s,
                        input logic [31:0] ii, input logic [31:0] ip, input logic ib,
                        input logic [4:0] ie, input logic iv,
                        input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] ep8,
                        input logic eb_, input logic [4:0] ee, input logic ev,
                        input logic [7:0] ec, input logic el);
    exp_t e;
    @(negedge clk);
    ifa.req = r; ifa.flush = f; ifa.stall = s;
    ifa.in_instr = ii; ifa.in_pc = ip; ifa.in_bd = ib; ifa.in_exc = ie; ifa.in_valid = iv;
    e.s.instr = ei; e.s.pc = ep; e.s.bd = eb_; e.s.exc = ee; e.s.valid = ev;
    e.pc8 = ep8; e.cnt = ec; e.lng = el;
    qa.push_back(e);
    @(posedge clk);
  endtask

  task automatic step_b(input logic f, input logic s, input logic [7:0] ec, input logic el);
    exp_t e;
    @(negedge clk);
    ifb.flush = f; ifb.stall = s;
    e.s = '0; e.pc8 = '0; e.cnt = ec; e.lng = el;
    qb.push_back(e);
    @(posedge clk);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_instr"}, ifa.out_instr, 32'h0000_0000);
    chk({tag, "_pc"},    ifa.out_pc,    32'h0000_3000);
    chk({tag, "_pc8"},   ifa.out_pc8,   32'h0000_3008);
    chk({tag, "_bd"},    32'(ifa.out_bd), 32'd0);
    chk({tag, "_exc"},   32'(ifa.out_exc), 32'd0);
    chk({tag, "_valid"}, 32'(ifa.out_valid), 32'd0);
    chk({tag, "_cnt"},   32'(ifa.stall_cnt), 32'd0);
    chk({tag, "_long"},  32'(ifa.stall_long), 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a_instr", ifa.out_instr, ea.s.instr);
      chk("a_pc",    ifa.out_pc,    ea.s.pc);
      chk("a_pc8",   ifa.out_pc8,   ea.pc8);
      chk("a_bd",    32'(ifa.out_bd),    32'(ea.s.bd));
      chk("a_exc",   32'(ifa.out_exc),   32'(ea.s.exc));
      chk("a_valid", 32'(ifa.out_valid), 32'(ea.s.valid));
      chk("a_cnt",   32'(ifa.stall_cnt), 32'(ea.cnt));
      chk("a_long",  32'(ifa.stall_long), 32'(ea.lng));
    end
  end

  always @(posedge clk) begin
    #1;
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b_cnt",  32'(ifb.stall_cnt),  32'(eb.cnt));
      chk("b_long", 32'(ifb.stall_long), 32'(eb.lng));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    ifa.req = 1'b0; ifa.flush = 1'b0; ifa.stall = 1'b0;
    ifa.in_instr = '0; ifa.in_pc = '0; ifa.in_bd = 1'b0; ifa.in_exc = '0; ifa.in_valid = 1'b0;
    ifb.req = 1'b0; ifb.flush = 1'b0; ifb.stall = 1'b0;
    ifb.in_instr = '0; ifb.in_pc = '0; ifb.in_bd = 1'b0; ifb.in_exc = '0; ifb.in_valid = 1'b0;

    // Reset asserted between edges must act without a clock edge.
    #12 reset = 1'b1;
    #1 chk_reset_a("rst0");
    chk("rst0_b_cnt", 32'(ifb.stall_cnt), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    //     r  f  s  in_instr      in_pc         bd ex        v   exp_instr     exp_pc        exp_pc8       bd ex        v  cnt   long
    step_a(0, 0, 0, 32'h8C010004, 32'h00003010, 0, 5'd0,     1,  32'h8C010004, 32'h00003010, 32'h00003018, 0, 5'd0,     1, 8'd0, 0);
    step_a(0, 0, 1, 32'hDEADBEEF, 32'h00005000, 1, 5'd3,     1,  32'h8C010004, 32'h00003010, 32'h00003018, 0, 5'd0,     1, 8'd1, 0);
    step_a(0, 0, 1, 32'hDEADBEEF, 32'h00005000, 1, 5'd3,     1,  32'h8C010004, 32'h00003010, 32'h00003018, 0, 5'd0,     1, 8'd2, 0);
    step_a(0, 0, 1, 32'hDEADBEEF, 32'h00005000, 1, 5'd3,     1,  32'h8C010004, 32'h00003010, 32'h00003018, 0, 5'd0,     1, 8'd3, 0);
    step_a(0, 1, 1, 32'h12345678, 32'h00003014, 1, EXC_ADEL, 1,  32'h00000000, 32'h00003014, 32'h0000301C, 1, 5'd0,     0, 8'd0, 0);
    step_a(0, 0, 0, 32'h24020001, 32'h00003018, 1, EXC_RI,   1,  32'h24020001, 32'h00003018, 32'h00003020, 1, 5'd10,    1, 8'd0, 0);
    step_a(0, 0, 1, 32'h00000000, 32'h00000000, 0, 5'd0,     0,  32'h24020001, 32'h00003018, 32'h00003020, 1, 5'd10,    1, 8'd1, 0);
    step_a(1, 1, 1, 32'h11111111, 32'h00002222, 1, 5'd7,     1,  32'h00000000, 32'h00004180, 32'h00004188, 0, 5'd0,     0, 8'd0, 0);
    step_a(0, 0, 0, 32'hAFBF0010, 32'hFFFFFFFC, 0, 5'd0,     1,  32'hAFBF0010, 32'hFFFFFFFC, 32'h00000004, 0, 5'd0,     1, 8'd0, 0);
    step_a(1, 0, 0, 32'h33333333, 32'h00003030, 1, 5'd5,     1,  32'h00000000, 32'h00004180, 32'h00004188, 0, 5'd0,     0, 8'd0, 0);
    step_a(0, 0, 1, 32'h44444444, 32'h00003034, 0, 5'd0,     1,  32'h00000000, 32'h00004180, 32'h00004188, 0, 5'd0,     0, 8'd1, 0);
    step_a(0, 1, 0, 32'h55555555, 32'h00004184, 0, EXC_OV,   1,  32'h00000000, 32'h00004184, 32'h0000418C, 0, 5'd0,     0, 8'd0, 0);
    step_a(0, 0, 0, 32'h8C020008, 32'h00003020, 0, EXC_ADEL, 1,  32'h8C020008, 32'h00003020, 32'h00003028, 0, 5'd4,     1, 8'd0, 0);
    step_a(0, 0, 1, 32'h00000000, 32'h00000000, 1, 5'd0,     0,  32'h8C020008, 32'h00003020, 32'h00003028, 0, 5'd4,     1, 8'd1, 0);
    step_a(0, 0, 1, 32'h00000000, 32'h00000000, 1, 5'd0,     0,  32'h8C020008, 32'h00003020, 32'h00003028, 0, 5'd4,     1, 8'd2, 0);

    // Reset in the middle of a stall: immediate return to reset values, counter restarts.
    #3 reset = 1'b1;
    #1 chk_reset_a("rst1");
    @(posedge clk);
    #2 reset = 1'b0;
    step_a(0, 0, 1, 32'h99999999, 32'h00009999, 1, 5'd9,     1,  32'h00000000, 32'h00003000, 32'h00003008, 0, 5'd0,     0, 8'd1, 0);
    step_a(0, 0, 0, 32'h00430820, 32'h00003024, 0, 5'd0,     1,  32'h00430820, 32'h00003024, 32'h0000302C, 0, 5'd0,     1, 8'd0, 0);

    // Narrow counter: threshold at 5, saturation at 7.
    step_b(0, 1, 8'd1, 0);
    step_b(0, 1, 8'd2, 0);
    step_b(0, 1, 8'd3, 0);
    step_b(0, 1, 8'd4, 0);
    step_b(0, 1, 8'd5, 1);
    step_b(0, 1, 8'd6, 1);
    step_b(0, 1, 8'd7, 1);
    step_b(0, 1, 8'd7, 1);
    step_b(0, 1, 8'd7, 1);
    step_b(0, 1, 8'd7, 1);
    step_b(0, 0, 8'd0, 0);
    step_b(0, 1, 8'd1, 0);
    step_b(1, 1, 8'd0, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("qa_drain", 32'(qa.size()), 32'd0);
    chk("qb_drain", 32'(qb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage register for the five-stage pipeline. It replaces the per-stage fixed registers (F/D, D/E, E/M, M/W) with one block that carries the instruction, PC, PC+8, branch-delay flag, exception code and valid bit. It supports four controls: hold (stall), bubble insertion (flush), exception redirect (req), and a saturating stall-length monitor. One instance sits between each pair of adjacent stages.

## Interface
Parameters:
- INSTR_W, 32, instruction field width
- PC_W, 32, PC field width
- EXC_W, 5, exception-code width; 0 means no exception
- RESET_PC, 32'h0000_3000, PC loaded on reset
- HANDLER_PC, 32'h0000_4180, PC loaded on req
- NOP, 32'h0000_0000, instruction injected on bubble
- CNT_W, 8, stall-counter width
- STALL_LIMIT, 8'd64, threshold for stall_long

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- req  in  1  exception/interrupt redirect; highest priority after reset
- flush  in  1  insert bubble
- stall  in  1  hold current contents
- in_instr  in  INSTR_W  upstream instruction
- in_pc  in  PC_W  upstream PC
- in_bd  in  1  upstream instruction is in a delay slot
- in_exc  in  EXC_W  upstream exception code
- in_valid  in  1  upstream slot holds a real instruction
- out_instr  out  INSTR_W  registered instruction
- out_pc  out  PC_W  registered PC
- out_pc8  out  PC_W  registered PC+8, modulo 2^PC_W
- out_bd  out  1  registered delay-slot flag
- out_exc  out  EXC_W  registered exception code
- out_valid  out  1  registered valid
- stall_cnt  out  CNT_W  current consecutive-stall length, saturating
- stall_long  out  1  registered; high when stall_cnt >= STALL_LIMIT

## Operation
Reset is asynchronous, active-high, and overrides everything. While reset is asserted:
- out_instr = NOP, out_pc = RESET_PC, out_pc8 = RESET_PC+8
- out_bd = 0, out_exc = 0, out_valid = 0
- stall_cnt = 0, stall_long = 0

Per-edge priority is req > flush > stall > load:
- **req:** out_instr=NOP, out_pc=HANDLER_PC, out_pc8=HANDLER_PC+8, out_bd=0, out_exc=0, out_valid=0.
- **flush (bubble):** out_instr=NOP, out_pc=in_pc, out_pc8=in_pc+8, out_bd=in_bd, out_exc=0, out_valid=0. The bubble keeps the PC and BD of the instruction it displaces, for precise EPC.
- **stall:** every data output holds its value.
- **load:** every field takes its in_* value; out_pc8 = in_pc+8.

Stall counter:
- Increments on an edge where stall=1 and req=0 and flush=0.
- Saturates at 2^CNT_W-1.
- Clears to 0 on any other edge.

stall_long is registered from the next-state count.

Width rule: the PC+8 adder is PC_W bits, and carry is discarded (0xFFFF_FFFC+8 = 0x0000_0004).

## Timing
- Latency is one cycle for every field; there is no combinational path from any in_* to any out_*.
- Control inputs are sampled only at the rising edge.
- Reset deassertion: the first load happens at the first rising edge after reset falls.
- flush and stall together produce a bubble, not a hold. Upstream must hold its own contents for that cycle.
- req together with any other control: the req behaviour wins.
- The stall counter clears on req or flush.
- Reset mid-stall: all outputs return to reset values immediately. The counter restarts from 0.

## Structure
- Package pipe_pkg holds:
  - shared constants: NOP, RESET_PC, HANDLER_PC
  - EXC_W and the exception-code localparams (e.g. EXC_ADEL=4, EXC_RI=10)
  - a typedef for the stage bundle {instr, pc, bd, exc, valid}
- One sub-module is natural: sat_counter (CNT_W parameter; inc and clr inputs, count output). It is instantiated for the stall monitor.
- The data path stays in the top module, with the next-state select followed by a single always block under asynchronous reset.

## Test plan
- **Reset:** assert reset asynchronously between clock edges -> outputs go to instr 0, pc 0x3000, pc8 0x3008, valid 0 without waiting for an edge.
- **Load then stall:** load pc 0x3010, instr 0x8C01_0004, valid 1, then stall for 3 cycles -> outputs hold 0x3010 / 0x8C01_0004; stall_cnt reads 1, 2, 3.
- **Flush during stall:** flush=1, stall=1, in_pc 0x3014, in_bd 1, in_exc 4 -> out_instr 0, out_pc 0x3014, out_pc8 0x301C, out_bd 1, out_exc 0, out_valid 0, stall_cnt 0.
- **Redirect priority:** req=1, flush=1, stall=1 -> out_pc 0x4180, out_pc8 0x4188, bd 0, valid 0.
- **Long stall:** CNT_W=3, STALL_LIMIT=5, stall held for 10 cycles -> stall_long rises at count 5; count saturates at 7; one load clears both to 0.
- **PC wrap:** load in_pc 0xFFFF_FFFC -> out_pc8 0x0000_0004.
